// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the write/read command queues feeding the bus framer.
// Holds default widths, the sequencer state encoding and a saturating counter helper.
package wb_write_queue_pkg;

  localparam int unsigned DEF_ADDR  = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ABITS = 2;
  localparam int unsigned DEF_RETRY = 3;
  localparam int unsigned DROPS_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } wbq_state_e;

  function automatic logic [DROPS_W-1:0] sat_inc(input logic [DROPS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_write_fifo.sv
// Small synchronous FIFO holding {addr, data} write commands.
// Pointers carry one extra wrap bit; full/empty are registered from the next pointers.
module wb_write_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned ABITS = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned DEPTH = 1 << ABITS;

  logic [ABITS:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS:0] rd_ptr_q, rd_ptr_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           do_push, do_pop;
  logic [DW-1:0]  mem_q [DEPTH];

  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q + {{ABITS{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{ABITS{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ABITS] != rd_ptr_d[ABITS]) &&
               (wr_ptr_d[ABITS-1:0] == rd_ptr_d[ABITS-1:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[ABITS-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[ABITS-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/wb_write_queue.sv
// Buffers producer write commands and sequences them one at a time into the bus framer,
// re-issuing failed writes a bounded number of times before dropping them with a sticky error.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int unsigned ADDR  = DEF_ADDR,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ABITS = DEF_ABITS,
  parameter int unsigned RETRY = DEF_RETRY
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [ADDR-1:0]    addr_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               write_o,
  output logic [ADDR-1:0]    adr_o,
  output logic [WIDTH-1:0]   dat_o,
  input  logic               busy_i,
  input  logic               done_i,
  input  logic               fail_i,
  output logic               idle_o,
  output logic               error_o,
  input  logic               clear_i,
  output logic [DROPS_W-1:0] drops_o,
  output wbq_state_e         dbg_state_o
);

  localparam int unsigned DW = ADDR + WIDTH;
  localparam int unsigned RW = (RETRY < 1) ? 1 : $clog2(RETRY + 1);

  // Handshake: a command transfers on a clock edge where valid_i && ready_o; ready_o is
  // a flop-derived !full, so a full FIFO refuses the push even if the head pops that cycle.
  wbq_state_e         state_q, state_d;
  logic               write_q, write_d;
  logic               idle_q, idle_d;
  logic               error_q, error_d;
  logic [ADDR-1:0]    adr_q, adr_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [DROPS_W-1:0] drops_q, drops_d;

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [DW-1:0]      head;

  assign push = valid_i && !fifo_full;

  wb_write_fifo #(
    .DW    (DW),
    .ABITS (ABITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({addr_i, data_i}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    retry_d = retry_q;
    error_d = error_q;
    drops_d = drops_q;
    pop     = 1'b0;

    if (clear_i) begin
      error_d = 1'b0;
      drops_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy_i) begin
          state_d = ST_ISSUE;
          adr_d   = head[DW-1:WIDTH];
          dat_d   = head[WIDTH-1:0];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // fail_i takes priority so a simultaneous done/fail is handled as a failure.
        if (fail_i) begin
          state_d = ST_IDLE;
          if (retry_q < RW'(RETRY)) begin
            retry_d = retry_q + 1'b1;
          end else begin
            pop     = 1'b1;
            retry_d = '0;
            error_d = 1'b1;
            drops_d = sat_inc(drops_d);
          end
        end else if (done_i) begin
          state_d = ST_IDLE;
          pop     = 1'b1;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    write_d = (state_d == ST_ISSUE);
    idle_d  = (state_q == ST_IDLE) && fifo_empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      idle_q  <= 1'b1;
      error_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      retry_q <= '0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      idle_q  <= idle_d;
      error_q <= error_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      retry_q <= retry_d;
      drops_q <= drops_d;
    end
  end

  assign ready_o     = !fifo_full;
  assign write_o     = write_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign idle_o      = idle_q;
  assign error_o     = error_q;
  assign drops_o     = drops_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: a framer model answers each write pulse, a queue-based
// reference tracks accepted commands, and a monitor checks every issued write against it.
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int ADDR  = 4;
  localparam int WIDTH = 8;
  localparam int ABITS = 2;
  localparam int RETRY = 3;
  localparam int DEPTH = 4;
  localparam int DW    = ADDR + WIDTH;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [ADDR-1:0]  addr_i;
  logic [WIDTH-1:0] data_i;
  logic             write_o;
  logic [ADDR-1:0]  adr_o;
  logic [WIDTH-1:0] dat_o;
  logic             busy_i;
  logic             done_i;
  logic             fail_i;
  logic             idle_o;
  logic             error_o;
  logic             clear_i;
  logic [3:0]       drops_o;
  wbq_state_e       dbg_state;

  logic             clear_drv;
  logic             clear_frm;
  assign clear_i = clear_drv | clear_frm;

  wb_write_queue #(
    .ADDR (ADDR), .WIDTH (WIDTH), .ABITS (ABITS), .RETRY (RETRY)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .write_o     (write_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .busy_i      (busy_i),
    .done_i      (done_i),
    .fail_i      (fail_i),
    .idle_o      (idle_o),
    .error_o     (error_o),
    .clear_i     (clear_i),
    .drops_o     (drops_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  int   occ        = 0;
  bit   mdl_error  = 0;
  int   mdl_drops  = 0;

  // framer model controls
  bit   fail_plan[$];
  int   lat_min = 1, lat_max = 1, fail_pct = 0;
  bit   both_ok = 0, clear_on_drop = 0;
  bit   resp_pending = 0, resp_fail = 0, resp_final = 0, resp_both = 0, resp_final_drv = 0;
  int   resp_cnt = 0, head_attempts = 0;
  int   pulses = 0;
  bit   prev_write = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Commands enter when the queue has room (occupancy before the edge) and leave when
  // the framer gives the final answer for them; drops raise the sticky error.
  always @(posedge clk_i or posedge rst_i) begin : model_upd
    bit acc, pop_e, drop_e;
    if (rst_i) begin
      exp_q.delete();
      occ       = 0;
      mdl_error = 0;
      mdl_drops = 0;
    end else begin
      acc    = valid_i && (occ < DEPTH);
      pop_e  = (done_i || fail_i) && resp_final_drv;
      drop_e = pop_e && fail_i;
      if (pop_e && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({addr_i, data_i});
      occ = occ + int'(acc) - int'(pop_e);
      if (clear_i) begin
        mdl_error = 0;
        mdl_drops = 0;
      end
      if (drop_e) begin
        mdl_error = 1;
        if (mdl_drops < 15) mdl_drops++;
      end
    end
  end

  // ---------------- framer model ----------------
  always @(negedge clk_i or posedge rst_i) begin
    done_i         = 1'b0;
    fail_i         = 1'b0;
    clear_frm      = 1'b0;
    resp_final_drv = 1'b0;
    if (rst_i) begin
      resp_pending  = 0;
      head_attempts = 0;
    end else begin
      if (resp_pending) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_pending = 0;
          if (resp_fail) begin
            fail_i = 1'b1;
            done_i = resp_both;
          end else begin
            done_i = 1'b1;
          end
          resp_final_drv = resp_final;
          if (resp_final) head_attempts = 0;
          if (resp_final && resp_fail && clear_on_drop) clear_frm = 1'b1;
        end
      end
      if (write_o) begin
        head_attempts++;
        resp_pending = 1;
        resp_cnt     = $urandom_range(lat_max, lat_min);
        if (fail_plan.size() > 0) resp_fail = fail_plan.pop_front();
        else resp_fail = ($urandom_range(99, 0) < fail_pct);
        resp_both  = resp_fail && both_ok && ($urandom_range(1, 0) == 1);
        resp_final = !resp_fail || (head_attempts > RETRY);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    #1;
    if (rst_i) begin
      prev_write = 0;
    end else begin
      check("ready_o", ready_o, occ < DEPTH);
      check("error_o", error_o, mdl_error);
      check("drops_o", drops_o, mdl_drops);
      if (write_o) begin
        pulses++;
        check("write_pulse_len", prev_write, 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL write_unexpected: write_o=1 adr=0x%0h dat=0x%0h with nothing queued", adr_o, dat_o);
        end else begin
          check("issue_adr_dat", {adr_o, dat_o}, exp_q[0]);
        end
      end
      if ((done_i || fail_i) && exp_q.size() > 0) check("held_adr_dat", {adr_o, dat_o}, exp_q[0]);
      prev_write = write_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_cmd(input logic [ADDR-1:0] a, input logic [WIDTH-1:0] d);
    valid_i = 1'b1;
    addr_i  = a;
    data_i  = d;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d entries still queued after %0d cycles", exp_q.size(), budget);
    end
    tick(2);
    #2;
    check("idle_after_drain", idle_o, 1);
  endtask

  task automatic add_fails(input int n);
    for (int i = 0; i < n; i++) fail_plan.push_back(1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int n;
    rst_i     = 1'b1;
    valid_i   = 1'b0;
    addr_i    = '0;
    data_i    = '0;
    busy_i    = 1'b0;
    clear_drv = 1'b0;
    tick(2);
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_idle", idle_o, 1);
    check("rst_write", write_o, 0);
    check("rst_error", error_o, 0);
    check("rst_drops", drops_o, 0);
    check("rst_adr_dat", {adr_o, dat_o}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick(1);

    // single write with fixed framer latency
    lat_min = 2; lat_max = 2;
    push_cmd(4'h3, 8'hA5);
    #1;
    check("latency_early", write_o, 0);
    @(negedge clk_i);
    #1;
    check("latency_write", write_o, 1);
    check("single_adr", adr_o, 4'h3);
    check("single_dat", dat_o, 8'hA5);
    wait_drain(50);

    // fill with framer stalled, fifth push refused
    lat_min = 1; lat_max = 3;
    busy_i = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(4'(i), 8'h10 + 8'(i));
    #1;
    check("full_ready", ready_o, 0);
    tick(2);
    busy_i = 1'b0;
    wait_drain(200);

    // retry then succeed
    p0 = pulses;
    add_fails(2);
    fail_plan.push_back(1'b0);
    push_cmd(4'h5, 8'h3C);
    wait_drain(100);
    check("retry_pulses", pulses - p0, 3);
    check("retry_error", error_o, 0);
    check("retry_drops", drops_o, 0);

    // retries exhausted, next entry still issues
    p0 = pulses;
    add_fails(RETRY + 1);
    fail_plan.push_back(1'b0);
    push_cmd(4'h9, 8'h66);
    push_cmd(4'hC, 8'h99);
    wait_drain(200);
    check("exhaust_pulses", pulses - p0, RETRY + 2);
    check("exhaust_error", error_o, 1);
    check("exhaust_drops", drops_o, 1);

    // clear in the same cycle as a drop: the drop wins
    clear_on_drop = 1;
    add_fails(RETRY + 1);
    push_cmd(4'h7, 8'h11);
    wait_drain(100);
    clear_on_drop = 0;
    check("clr_drop_error", error_o, 1);
    check("clr_drop_drops", drops_o, 1);

    // asynchronous reset with a write in flight and three behind it
    busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(4'hA + 4'(i), 8'hC0 + 8'(i));
    busy_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!write_o && n < 20);
    check("pre_reset_write", write_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_write", write_o, 0);
    check("async_error", error_o, 0);
    check("async_ready", ready_o, 1);
    check("async_drops", drops_o, 0);
    tick(2);
    rst_i = 1'b0;
    p0 = pulses;
    tick(10);
    #1;
    check("post_reset_idle", idle_o, 1);
    check("post_reset_pulses", pulses - p0, 0);

    // drop, then clear on its own
    add_fails(RETRY + 1);
    push_cmd(4'h2, 8'h5A);
    wait_drain(100);
    check("drop2_error", error_o, 1);
    clear_drv = 1'b1;
    @(negedge clk_i);
    clear_drv = 1'b0;
    #1;
    check("clear_error", error_o, 0);
    check("clear_drops", drops_o, 0);

    // randomized traffic
    lat_min = 1; lat_max = 4; fail_pct = 30; both_ok = 1;
    for (int i = 0; i < 60; i++) begin
      busy_i    = ($urandom_range(9, 0) < 2);
      clear_drv = ($urandom_range(15, 0) == 0);
      if ($urandom_range(1, 0) == 1) push_cmd(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
      else tick(1);
    end
    busy_i    = 1'b0;
    clear_drv = 1'b0;
    wait_drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
